// File: rtl/stream_frame_scheduler_if.sv
// rtl/stream_frame_scheduler_if.sv - AXI-Stream style beat interface for the frame scheduler
interface stream_frame_scheduler_if #(
  parameter int DATA_W = 64
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/stream_frame_scheduler.sv
// rtl/stream_frame_scheduler.sv - start-delay / fixed-length frame / gap sequencer for an activation stream
module stream_frame_scheduler #(
  parameter int NUM_PE = 8,
  parameter int ACT_BW = 8,
  parameter int CNT_BW = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic                    cfg_start,
  input  logic [CNT_BW-1:0]       cfg_init_wait,
  input  logic [CNT_BW-1:0]       cfg_frame_len,
  input  logic [CNT_BW-1:0]       cfg_gap,
  input  logic [CNT_BW-1:0]       cfg_num_frames,
  stream_frame_scheduler_if.slave  s_axis,
  stream_frame_scheduler_if.master m_axis,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_BW-1:0]       frame_cnt,
  output logic [CNT_BW-1:0]       beat_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CNT_BW-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BW-1:0] CNT_ONE  = {{(CNT_BW-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [CNT_BW-1:0] init_wait_q;
  logic [CNT_BW-1:0] frame_len_q;
  logic [CNT_BW-1:0] gap_q;
  logic [CNT_BW-1:0] num_frames_q;
  logic [CNT_BW-1:0] wait_cnt;
  logic [CNT_BW-1:0] beat_cnt_q;
  logic [CNT_BW-1:0] frame_cnt_q;

  logic              in_stream;
  logic              out_valid;
  logic              out_last;
  logic              xfer;
  logic              last_frame;
  logic [CNT_BW-1:0] wait_lim;
  logic              wait_over;

  // Pure pass-through while streaming; the handshake is gated shut in every other state
  assign in_stream     = (state == ST_STREAM);
  assign out_valid     = in_stream & s_axis.tvalid;
  assign s_axis.tready = in_stream & m_axis.tready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = s_axis.tdata;

  // frame_len_q is nonzero whenever STREAM is reachable, so the -1 never underflows there
  assign out_last      = in_stream & (beat_cnt_q == frame_len_q - CNT_ONE);
  assign m_axis.tlast  = out_last;
  assign xfer          = out_valid & m_axis.tready;
  assign last_frame    = (frame_cnt_q == num_frames_q - CNT_ONE);

  // INIT_WAIT and GAP share one idle counter; only the limit differs
  assign wait_lim      = (state == ST_GAP) ? gap_q : init_wait_q;
  assign wait_over     = (wait_cnt == wait_lim - CNT_ONE);

  assign busy          = (state == ST_INIT) | (state == ST_STREAM) | (state == ST_GAP);
  assign done          = (state == ST_DONE);
  assign frame_cnt     = frame_cnt_q;
  assign beat_cnt      = beat_cnt_q;

  // Sequencer: latch config on start, count idle cycles, beats and frames
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state        <= ST_IDLE;
      init_wait_q  <= CNT_ZERO;
      frame_len_q  <= CNT_ZERO;
      gap_q        <= CNT_ZERO;
      num_frames_q <= CNT_ZERO;
      wait_cnt     <= CNT_ZERO;
      beat_cnt_q   <= CNT_ZERO;
      frame_cnt_q  <= CNT_ZERO;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            init_wait_q  <= cfg_init_wait;
            frame_len_q  <= cfg_frame_len;
            gap_q        <= cfg_gap;
            num_frames_q <= cfg_num_frames;
            wait_cnt     <= CNT_ZERO;
            beat_cnt_q   <= CNT_ZERO;
            frame_cnt_q  <= CNT_ZERO;
            // Decide from the incoming values since the latched copies update on this same edge
            if ((cfg_frame_len == CNT_ZERO) || (cfg_num_frames == CNT_ZERO)) begin
              state <= ST_DONE;
            end else if (cfg_init_wait == CNT_ZERO) begin
              state <= ST_STREAM;
            end else begin
              state <= ST_INIT;
            end
          end
        end
        ST_INIT, ST_GAP: begin
          if (wait_over) begin
            wait_cnt <= CNT_ZERO;
            state    <= ST_STREAM;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            if (out_last) begin
              beat_cnt_q  <= CNT_ZERO;
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
              if (last_frame) begin
                state <= ST_DONE;
              end else if (gap_q != CNT_ZERO) begin
                state <= ST_GAP;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_frame_scheduler.md
Name: stream_frame_scheduler

Overview:
- Synthesizable AXI-Stream scheduler between an activation source (stimulus memory or DMA, slave side) and the EdgeDRNN input port (master side).
- Holds the stream for a configurable start-up delay, then passes frames of a fixed beat count, generating tlast on each frame's final beat.
- Inserts a configurable idle gap between frames and stops after a programmed frame count.
- Replaces free-running, ad-hoc input pacing with a deterministic, configurable sequencer.

Parameters:
NUM_PE, 8, number of PEs; data beat is NUM_PE*ACT_BW bits
ACT_BW, 8, activation bit width per PE
CNT_BW, 16, width of all configuration values and counters

Ports:
s_axi_aclk  input  1  clock
s_axi_areset  input  1  asynchronous reset, active-high
cfg_start  input  1  single-cycle start pulse; latches all cfg_* values
cfg_init_wait  input  CNT_BW  idle cycles before first frame
cfg_frame_len  input  CNT_BW  beats per frame
cfg_gap  input  CNT_BW  idle cycles between frames
cfg_num_frames  input  CNT_BW  frames to send
s_axis_tvalid  input  1  source beat valid
s_axis_tready  output  1  source beat accepted
s_axis_tdata  input  NUM_PE*ACT_BW  source beat
m_axis_tvalid  output  1  beat valid to DRNN
m_axis_tready  input  1  DRNN ready
m_axis_tdata  output  NUM_PE*ACT_BW  beat to DRNN
m_axis_tlast  output  1  last beat of frame
busy  output  1  high in INIT_WAIT, STREAM, GAP
done  output  1  high in DONE
frame_cnt  output  CNT_BW  frames completed in the current run
beat_cnt  output  CNT_BW  beats transferred in the current frame

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All counters and latched config clear to 0.
  - m_axis_tvalid, s_axis_tready, m_axis_tlast, busy and done are 0 immediately.
  - A transfer in flight is abandoned; no completion is owed.
- Handshake:
  - In STREAM only: m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, m_axis_tdata = s_axis_tdata. This is a combinational pass-through with zero latency and no buffering.
  - In all other states: m_axis_tvalid = 0, s_axis_tready = 0. m_axis_tdata is driven with s_axis_tdata but is don't-care.
  - A beat transfers when m_axis_tvalid and m_axis_tready are both high.
- m_axis_tlast = (state == STREAM) and (beat_cnt == frame_len_q-1). It is combinational and held while the beat stalls.
- States:
  - IDLE: waits for cfg_start.
    - On cfg_start: latch cfg_* into *_q registers and clear all counters.
    - If frame_len_q == 0 or num_frames_q == 0, go to DONE.
    - Else if init_wait_q == 0, go to STREAM.
    - Else go to INIT_WAIT.
  - INIT_WAIT: wait_cnt increments every cycle. When wait_cnt == init_wait_q-1, clear wait_cnt and go to STREAM. The block spends exactly init_wait_q cycles here.
  - STREAM: beat_cnt increments on each transfer. On the transfer with tlast:
    - beat_cnt goes to 0 and frame_cnt increments.
    - If frame_cnt == num_frames_q-1 before the increment, go to DONE.
    - Else if gap_q == 0, stay in STREAM; back-to-back frames are allowed.
    - Else go to GAP.
  - GAP: same as INIT_WAIT but uses gap_q. Exactly gap_q idle cycles, then STREAM.
  - DONE: done = 1 and frame_cnt holds its final value.
    - cfg_start restarts exactly as from IDLE.
    - done drops the cycle after the start pulse.
- cfg_start while busy is ignored. Config changes mid-run have no effect; only the latched copies are used.
- Counter arithmetic:
  - Counters are unsigned CNT_BW and never wrap within a legal run, since all maxima are at most 2^CNT_BW-1.
  - Comparisons against value-1 are only evaluated when that value is nonzero.
- A source stall (s_axis_tvalid = 0) or sink stall (m_axis_tready = 0) in STREAM freezes beat_cnt. The state does not change.
- Beats offered by the source outside STREAM are not consumed.

Test Plan:
- Basic run: init_wait=5, frame_len=4, gap=3, num_frames=2, source and sink always ready → no m_axis_tvalid for 5 cycles after start; 4 beats with tlast on beat 4; 3 idle cycles; 4 beats with tlast; done=1, frame_cnt=2. Data equals source order.
- Back-pressure: frame_len=8, m_axis_tready toggling 1/0 and s_axis_tvalid low every third cycle → exactly 8 transfers with no duplication or loss; tlast held stable while stalled on beat 8; beat_cnt frozen during stalls.
- Zero cases: init_wait=0, gap=0, frame_len=1, num_frames=3 → tvalid on the first cycle after start; 3 consecutive beats each with tlast; done afterwards. A separate run with num_frames=0 → DONE one cycle after start, zero beats.
- Start while busy: a second cfg_start with changed cfg values in the middle of frame 1 → ignored; the run completes with the originally latched values.
- Reset mid-frame: assert s_axi_areset asynchronously on beat 2 of 4 → m_axis_tvalid, busy and counters go to 0 before the next clock edge. After release, a new cfg_start runs a full clean sequence.
- Restart from DONE: cfg_start in DONE with new values (frame_len=2, num_frames=1) → done drops the next cycle; 2 beats with tlast on the second; done again with frame_cnt=1.
